spi_access_arbiter: RTL
=======================

Name: spi_access_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single HDP register-access SPI engine between several requesters, such as the startup/shutdown sequencer, runtime row-address updater and UART debug bridge.
- Accepts one register read or write per requester.
- Issues exactly one SPI transaction at a time.
- Returns completion and read data to the owning requester.
- Sits between the requesters and the SPI engine, and is the only driver of the engine's begin/address/data inputs.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT_CYCLES, 4000000, max cycles waiting for SPI done before abort (timeout build only)

Ports:
i_clock  in  1  system clock
i_resetN  in  1  asynchronous active-low reset
i_req  in  NUM_REQ  per-requester request level; held until matching o_done
i_write  in  NUM_REQ  1 = register write, 0 = register read
i_addr  in  7*NUM_REQ  register address, requester k at bits [7k+6:7k]
i_wdata  in  8*NUM_REQ  write data, requester k at bits [8k+7:8k]
o_grant  out  NUM_REQ  one-hot owner of the current transaction, held ISSUE..COMPLETE
o_done  out  NUM_REQ  one-cycle completion pulse to owner
o_rdata  out  8  read data, valid while o_done asserted
o_error  out  1  asserted with o_done when transaction timed out
o_spiTxBegin  out  1  one-cycle write start to SPI engine
o_spiTxAddress  out  7  write address
o_spiTxData  out  8  write data
o_spiRxBegin  out  1  one-cycle read start to SPI engine
o_spiRxAddress  out  7  read address
i_spiTxBusy  in  1  engine write busy
i_spiRxBusy  in  1  engine read busy
i_spiTxDone  in  1  engine write done pulse
i_spiRxDone  in  1  engine read done pulse
i_spiRxData  in  8  engine read data, valid with i_spiRxDone

Behaviour:
- Reset (async, i_resetN=0):
  - State is IDLE.
  - All outputs are 0.
  - Round-robin pointer is NUM_REQ-1, so requester 0 wins first.
  - Timeout counter is 0.
- Reset mid-transaction: outputs clear immediately. Any in-flight SPI transfer is abandoned; the engine completes it on its own and the resulting done pulse is ignored because state is IDLE.
- State machine:
  - IDLE:
    - Condition to leave: any i_req bit set, and i_spiTxBusy=0, and i_spiRxBusy=0.
    - Winner: first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
    - Latch winner index, write flag, addr and wdata.
    - Set o_grant.
    - Go to ISSUE.
  - ISSUE (1 cycle): pulse o_spiTxBegin (write) or o_spiRxBegin (read) with latched address/data. Go to WAIT.
  - WAIT:
    - On i_spiTxDone (write) or i_spiRxDone (read), capture i_spiRxData into o_rdata (reads only; writes return 0) and go to COMPLETE.
    - The done pulse of the opposite direction is ignored.
  - COMPLETE (1 cycle):
    - Pulse o_done[winner].
    - Update pointer to the winner.
    - Clear o_grant on exit and return to IDLE.
    - o_rdata holds until the next completion.
- Latency: i_req rising in IDLE at cycle N gives o_grant and the begin pulse at N+1 (ISSUE state, begin registered so visible N+1). o_done appears 1 cycle after the engine done pulse.
- Fairness:
  - A requester that has just been served has lowest priority next arbitration.
  - A requester still asserting i_req in the cycle after its o_done is treated as a new request.
  - Requesters must drop i_req in the cycle after o_done if they have no further work.
- i_req dropped by the owner mid-transaction: the transaction still completes and o_done still pulses.
- Simultaneous requests are resolved purely by the pointer; only one grant ever.
- Begin outputs are never asserted outside ISSUE. Address/data outputs hold latched values from ISSUE through COMPLETE.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entering WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES, go to COMPLETE with o_error=1 and o_rdata=0.
  - o_error is asserted only during the o_done cycle.
- Undefined: no counter; WAIT lasts indefinitely; o_error is tied 0.

Decomposition:
- Shared package spi_arb_pkg:
  - State encodings s_IDLE/s_ISSUE/s_WAIT/s_COMPLETE.
  - Address width 7 and data width 8 constants.
  - HDP register address constants (mode 0x01, serial row 0x06/0x07, serial command 0x08, clock 0x09, config 0x78).
- One sub-module rr_priority_pick: combinational round-robin search, inputs request vector and pointer, outputs one-hot grant and index.

Test Plan:
1. Single write: req[0]=1, write=1, addr=0x01, wdata=0x02 -> o_spiTxBegin 1 cycle after req with addr 0x01/data 0x02; o_done[0] 1 cycle after i_spiTxDone; o_error=0.
2. Single read: req[1]=1, read addr=0x78, engine returns 0x20 -> o_spiRxBegin with addr 0x78; o_done[1] with o_rdata=0x20.
3. Contention: req=3'b111 held, each serviced -> grant order 0,1,2,0 with no requester served twice in a row.
4. Busy gate: i_spiTxBusy=1 while req[2]=1 -> no begin pulse until busy falls; begin pulse on the cycle after busy drops.
5. Reset mid-WAIT: assert i_resetN=0 during WAIT, release, then pulse i_spiTxDone -> all outputs 0, no o_done; next request is granted to requester 0 first.
6. With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, read with no engine done -> o_done with o_error=1 and o_rdata=0 exactly 16 WAIT cycles after entry.

Source files
------------

// File: rtl/spi_access_arbiter_pkg.sv
// Shared types and constants for the HDP SPI access arbiter.
package spi_arb_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      s_IDLE,
      s_ISSUE,
      s_WAIT,
      s_COMPLETE
   } arb_state_t;

   // HDP register map entries used by the requesters
   localparam logic [ADDR_W-1:0] HDP_REG_MODE    = 7'h01;
   localparam logic [ADDR_W-1:0] HDP_REG_SROW_LO = 7'h06;
   localparam logic [ADDR_W-1:0] HDP_REG_SROW_HI = 7'h07;
   localparam logic [ADDR_W-1:0] HDP_REG_SCMD    = 7'h08;
   localparam logic [ADDR_W-1:0] HDP_REG_CLOCK   = 7'h09;
   localparam logic [ADDR_W-1:0] HDP_REG_CONFIG  = 7'h78;

endpackage

// File: rtl/spi_access_arbiter_if.sv
// Requester and SPI-engine signal bundle for spi_access_arbiter.
interface spi_access_arbiter_if
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
);

   logic [NUM_REQ-1:0]        i_req;
   logic [NUM_REQ-1:0]        i_write;
   logic [ADDR_W*NUM_REQ-1:0] i_addr;
   logic [DATA_W*NUM_REQ-1:0] i_wdata;
   logic [NUM_REQ-1:0]        o_grant;
   logic [NUM_REQ-1:0]        o_done;
   logic [DATA_W-1:0]         o_rdata;
   logic                      o_error;
   logic                      o_spiTxBegin;
   logic [ADDR_W-1:0]         o_spiTxAddress;
   logic [DATA_W-1:0]         o_spiTxData;
   logic                      o_spiRxBegin;
   logic [ADDR_W-1:0]         o_spiRxAddress;
   logic                      i_spiTxBusy;
   logic                      i_spiRxBusy;
   logic                      i_spiTxDone;
   logic                      i_spiRxDone;
   logic [DATA_W-1:0]         i_spiRxData;

   modport slave (
      input  i_req, i_write, i_addr, i_wdata,
      input  i_spiTxBusy, i_spiRxBusy, i_spiTxDone, i_spiRxDone, i_spiRxData,
      output o_grant, o_done, o_rdata, o_error,
      output o_spiTxBegin, o_spiTxAddress, o_spiTxData, o_spiRxBegin, o_spiRxAddress
   );

   modport master (
      output i_req, i_write, i_addr, i_wdata,
      output i_spiTxBusy, i_spiRxBusy, i_spiTxDone, i_spiRxDone, i_spiRxData,
      input  o_grant, o_done, o_rdata, o_error,
      input  o_spiTxBegin, o_spiTxAddress, o_spiTxData, o_spiRxBegin, o_spiRxAddress
   );

endinterface

// File: rtl/spi_access_arbiter_rr_priority_pick.sv
// Combinational round-robin search: first set request above ptr_i, wrapping.
module rr_priority_pick #(
   parameter int unsigned NUM_REQ = 3,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   int unsigned k;

   // ptr_i itself is searched last, giving the last winner lowest priority
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      k       = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         k = (32'(ptr_i) + i) % NUM_REQ;
         if (!valid_o && req_i[k]) begin
            gnt_o[k] = 1'b1;
            idx_o    = IDX_W'(k);
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_access_arbiter.sv
// Round-robin sharer of the HDP register-access SPI engine.
// Optional WAIT timeout abort enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_access_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 3,
   parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
   input logic                 i_clock,
   input logic                 i_resetN,
   spi_access_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t          state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                txb_q, txb_d;
   logic                rxb_q, rxb_d;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_valid;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                error_q, error_d;
`endif

   rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (bus.i_req),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         state_q <= s_IDLE;
         ptr_q   <= IDX_W'(NUM_REQ - 1);
         idx_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         grant_q <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         txb_q   <= 1'b0;
         rxb_q   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         error_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         txb_q   <= txb_d;
         rxb_q   <= rxb_d;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         error_q <= error_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      grant_d = grant_q;
      rdata_d = rdata_q;
      done_d  = '0;
      txb_d   = 1'b0;
      rxb_d   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      error_d = 1'b0;
`endif
      unique case (state_q)
         s_IDLE: begin
            if (pick_valid && !bus.i_spiTxBusy && !bus.i_spiRxBusy) begin
               idx_d   = pick_idx;
               write_d = bus.i_write[pick_idx];
               addr_d  = bus.i_addr[ADDR_W*pick_idx +: ADDR_W];
               wdata_d = bus.i_wdata[DATA_W*pick_idx +: DATA_W];
               grant_d = pick_gnt;
               txb_d   = bus.i_write[pick_idx];
               rxb_d   = !bus.i_write[pick_idx];
               state_d = s_ISSUE;
            end
         end
         s_ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            state_d = s_WAIT;
         end
         s_WAIT: begin
            if (write_q ? bus.i_spiTxDone : bus.i_spiRxDone) begin
               rdata_d        = write_q ? '0 : bus.i_spiRxData;
               done_d[idx_q]  = 1'b1;
               state_d        = s_COMPLETE;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rdata_d       = '0;
               error_d       = 1'b1;
               done_d[idx_q] = 1'b1;
               state_d       = s_COMPLETE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         s_COMPLETE: begin
            ptr_d   = idx_q;
            grant_d = '0;
            state_d = s_IDLE;
         end
         default: state_d = s_IDLE;
      endcase
   end

   assign bus.o_grant        = grant_q;
   assign bus.o_done         = done_q;
   assign bus.o_rdata        = rdata_q;
   assign bus.o_spiTxBegin   = txb_q;
   assign bus.o_spiTxAddress = addr_q;
   assign bus.o_spiTxData    = wdata_q;
   assign bus.o_spiRxBegin   = rxb_q;
   assign bus.o_spiRxAddress = addr_q;
`ifdef SPI_ARB_TIMEOUT_EN
   assign bus.o_error        = error_q;
`else
   assign bus.o_error        = 1'b0;
`endif

endmodule
